// File: rtl/onehot_dec_pkg.sv
// Shared definitions for the one-hot decode-and-hold block.
//   ST_IDLE / ST_HOLD : FSM state encodings (legacy-compatible localparams)
//   CODE_W / ONEHOT_W : encoded code width and decoded one-hot width
//   code2onehot()     : decode map, inverse of the 4-to-2 priority encoder
package onehot_dec_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Code 00 is the highest-priority line, so it maps to the MSB.
  function automatic logic [ONEHOT_W-1:0] code2onehot(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] onehot;
    case (code)
      2'b00:   onehot = 4'b1000;
      2'b01:   onehot = 4'b0100;
      2'b10:   onehot = 4'b0010;
      default: onehot = 4'b0001;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/onehot_decode_hold_if.sv
// Code-link and decoded-output bundle for onehot_decode_hold.
//   in_valid/in_ready/in_code/in_par : code stream handshake (master -> slave)
//   err_clr                          : synchronous clear of the sticky error
//   q/q_valid/busy/err               : decoded output and status (slave -> master)
// master = code source / downstream logic, slave = the decoder.
interface onehot_decode_hold_if;
  import onehot_dec_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                in_par;
  logic                err_clr;
  logic [ONEHOT_W-1:0] q;
  logic                q_valid;
  logic                busy;
  logic                err;

  modport master (
    output in_valid, in_code, in_par, err_clr,
    input  in_ready, q, q_valid, busy, err
  );

  modport slave (
    input  in_valid, in_code, in_par, err_clr,
    output in_ready, q, q_valid, busy, err
  );

endinterface

// File: rtl/onehot_dec_fifo.sv
// Synchronous FIFO buffering incoming codes ahead of the hold FSM.
//   clk, rst_n       : clock, async active-low reset (pointers only)
//   i_push / i_data  : write strobe and data (ignored while full)
//   i_pop            : read strobe (ignored while empty)
//   o_data           : head entry, combinational read
//   o_full / o_empty : occupancy flags
// Pointers carry one extra MSB; full when MSBs differ and the rest match.
module onehot_dec_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; empty pointers guard against reading stale data.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/onehot_decode_hold.sv
// Registered 2-to-4 one-hot decoder with input buffer and per-pattern hold.
//   clk, rst_n : clock, async active-low reset
//   bus        : onehot_decode_hold_if.slave (code stream in, q/status out)
// Parameters: HOLD_CYCLES (>=1) clocks per pattern, FIFO_DEPTH (power of 2, >=2).
// Optional feature macro PARITY_CHK_EN: beats whose in_par disagrees with
// ^in_code are acknowledged but discarded, and set the sticky err flag.
// Without it, in_par/err_clr are unused and err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | q = 0000, waiting for the FIFO to hold a code
// ST_HOLD | q holds a decoded pattern; r_cnt counts remaining clocks
module onehot_decode_hold
  import onehot_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_decode_hold_if.slave  bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ONEHOT_W-1:0] r_q;
  logic                r_q_valid;
  logic                r_err;

  logic                w_full;
  logic                w_empty;
  logic [CODE_W-1:0]   w_head;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_par_bad;

  assign w_accept = bus.in_valid & bus.in_ready;

`ifdef PARITY_CHK_EN
  // Odd parity across code+par means in_par != ^in_code.
  assign w_par_bad = w_accept & (^{bus.in_code, bus.in_par});
`else
  assign w_par_bad = 1'b0;
  logic w_unused;
  assign w_unused = ^{bus.in_par, bus.err_clr};
`endif

  assign w_push = w_accept & ~w_par_bad;

  // Pop when idle, or at terminal count so patterns run back-to-back.
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) | (r_cnt == '0));

  onehot_dec_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.in_code),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_pop) begin
      r_state   <= ST_HOLD;
      r_cnt     <= CNT_LOAD;
      r_q       <= code2onehot(w_head);
      r_q_valid <= 1'b1;
    end else if (r_state == ST_HOLD) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_state   <= ST_IDLE;
        r_q       <= '0;
        r_q_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHK_EN
  // A new error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_par_bad)  r_err <= 1'b1;
    else if (bus.err_clr) r_err <= 1'b0;
  end
`else
  assign r_err = 1'b0;
`endif

  assign bus.in_ready = ~w_full;
  assign bus.q        = r_q;
  assign bus.q_valid  = r_q_valid;
  assign bus.busy     = (r_state == ST_HOLD) | ~w_empty;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_onehot_decode_hold.sv
module tb_onehot_decode_hold;

  localparam int HOLD0 = 4;
  localparam int HOLD1 = 1;

  logic clk;
  logic rst_n;

  onehot_decode_hold_if bus0 ();
  onehot_decode_hold_if bus1 ();

  onehot_decode_hold #(.HOLD_CYCLES(HOLD0), .FIFO_DEPTH(4)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );
  onehot_decode_hold #(.HOLD_CYCLES(HOLD1), .FIFO_DEPTH(4)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp0[$];
  logic [3:0] exp1[$];
  logic [3:0] cur0, cur1;
  int rem0 = 0, rem1 = 0;
  int run1 = 0, maxrun1 = 0;
  int stalls[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitors: each expected pattern must appear for exactly HOLD clocks.
  always @(negedge clk) begin
    if (!rst_n) begin
      rem0 = 0;
    end else if (bus0.q_valid) begin
      if (rem0 == 0) begin
        if (exp0.size() == 0) fail("dut0_unexpected_pattern", bus0.q, 0);
        else begin
          cur0 = exp0.pop_front();
          rem0 = HOLD0 - 1;
          chk("dut0_q_first", bus0.q, cur0);
        end
      end else begin
        rem0--;
        chk("dut0_q_hold", bus0.q, cur0);
      end
    end else if (rem0 != 0) begin
      fail("dut0_hold_cut_short", rem0, 0);
      rem0 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rem1 = 0;
      run1 = 0;
    end else if (bus1.q_valid) begin
      run1++;
      if (run1 > maxrun1) maxrun1 = run1;
      if (rem1 == 0) begin
        if (exp1.size() == 0) fail("dut1_unexpected_pattern", bus1.q, 0);
        else begin
          cur1 = exp1.pop_front();
          rem1 = HOLD1 - 1;
          chk("dut1_q_first", bus1.q, cur1);
        end
      end else begin
        rem1--;
        chk("dut1_q_hold", bus1.q, cur1);
      end
    end else begin
      run1 = 0;
      if (rem1 != 0) begin
        fail("dut1_hold_cut_short", rem1, 0);
        rem1 = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
  task automatic push(input int d, input logic [1:0] code, input logic par,
                      input logic [3:0] exp, input bit store);
    bit rdy;
    int guard = 0;
    if (d == 0) begin
      bus0.in_valid = 1'b1; bus0.in_code = code; bus0.in_par = par;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_code = code; bus1.in_par = par;
    end
    do begin
      @(negedge clk);
      rdy = (d == 0) ? bus0.in_ready : bus1.in_ready;
      if (!rdy) stalls[d]++;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) fail("push_timeout", 0, 1);
    else if (store) begin
      if (d == 0) exp0.push_back(exp);
      else        exp1.push_back(exp);
    end
  endtask

  task automatic idle_in();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain(input int d);
    int guard = 0;
    bit done;
    do begin
      @(negedge clk);
      #1;
      if (d == 0) done = (exp0.size() == 0) && (rem0 == 0) && !bus0.q_valid;
      else        done = (exp1.size() == 0) && (rem1 == 0) && !bus1.q_valid;
      guard++;
    end while (!done && guard < 200);
    if (!done) fail("drain_timeout", d, 0);
  endtask

  int cycles;

  initial begin
    bus0.in_valid = 0; bus0.in_code = 0; bus0.in_par = 0; bus0.err_clr = 0;
    bus1.in_valid = 0; bus1.in_code = 0; bus1.in_par = 0; bus1.err_clr = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_q", bus0.q, 4'b0000);
    chk("reset_q_valid", bus0.q_valid, 0);
    chk("reset_busy", bus0.busy, 0);
    chk("reset_in_ready", bus0.in_ready, 1);
    chk("reset_err", bus0.err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single code 01, latency and exact hold length
    push(0, 2'b01, 1'b1, 4'b0100, 1);
    idle_in();
    chk("t1_not_yet_valid", bus0.q_valid, 0);
    chk("t1_busy_buffered", bus0.busy, 1);
    @(posedge clk); #1;
    chk("t1_q_at_n1", bus0.q, 4'b0100);
    cycles = 0;
    while (bus0.q_valid && cycles < 20) begin
      cycles++;
      @(posedge clk); #1;
    end
    chk("t1_hold_len", cycles, 4);
    chk("t1_q_cleared", bus0.q, 4'b0000);
    chk("t1_busy_idle", bus0.busy, 0);
    drain(0);

    // 2: back-to-back 00,11,10
    @(posedge clk); #1;
    push(0, 2'b00, 1'b0, 4'b1000, 1);
    push(0, 2'b11, 1'b0, 4'b0001, 1);
    push(0, 2'b10, 1'b1, 4'b0010, 1);
    idle_in();
    chk("t2_busy_during", bus0.busy, 1);
    drain(0);
    chk("t2_busy_after", bus0.busy, 0);

    // 3: six codes with no gaps overflow a 4-deep buffer
    @(posedge clk); #1;
    stalls[0] = 0;
    push(0, 2'b11, 1'b0, 4'b0001, 1);
    push(0, 2'b10, 1'b1, 4'b0010, 1);
    push(0, 2'b01, 1'b1, 4'b0100, 1);
    push(0, 2'b00, 1'b0, 4'b1000, 1);
    push(0, 2'b01, 1'b1, 4'b0100, 1);
    push(0, 2'b10, 1'b1, 4'b0010, 1);
    idle_in();
    chk("t3_stalled_when_full", stalls[0] > 0, 1);
    drain(0);

    // 4: async reset mid-hold on 0010 drops everything
    @(posedge clk); #1;
    push(0, 2'b10, 1'b1, 4'b0010, 1);
    push(0, 2'b01, 1'b1, 4'b0100, 1);
    push(0, 2'b11, 1'b0, 4'b0001, 1);
    idle_in();
    chk("t4_q_before_reset", bus0.q, 4'b0010);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp0.delete();
    #1;
    chk("t4_q_async", bus0.q, 4'b0000);
    chk("t4_q_valid_async", bus0.q_valid, 0);
    @(negedge clk);
    chk("t4_busy_in_reset", bus0.busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_after", bus0.in_ready, 1);
    chk("t4_empty_after", bus0.busy, 0);
    repeat (6) @(posedge clk);
    #1;

    // 5: parity-bad beat (code 10, par 0)
`ifdef PARITY_CHK_EN
    push(0, 2'b10, 1'b0, 4'b0010, 0);
    idle_in();
    chk("t5_err_set", bus0.err, 1);
    chk("t5_dropped", bus0.busy, 0);
    bus0.err_clr = 1'b1;
    push(0, 2'b01, 1'b0, 4'b0100, 0);
    idle_in();
    bus0.err_clr = 1'b0;
    chk("t5_set_beats_clr", bus0.err, 1);
    bus0.err_clr = 1'b1;
    @(posedge clk); #1;
    bus0.err_clr = 1'b0;
    chk("t5_lone_clr", bus0.err, 0);
`else
    push(0, 2'b10, 1'b0, 4'b0010, 1);
    idle_in();
    chk("t5_err_tied_low", bus0.err, 0);
    chk("t5_stored", bus0.busy, 1);
`endif
    drain(0);

    // 6: HOLD_CYCLES=1, four codes stream one per clock
    @(posedge clk); #1;
    stalls[1] = 0;
    maxrun1 = 0;
    push(1, 2'b11, 1'b0, 4'b0001, 1);
    push(1, 2'b00, 1'b0, 4'b1000, 1);
    push(1, 2'b01, 1'b1, 4'b0100, 1);
    push(1, 2'b10, 1'b1, 4'b0010, 1);
    idle_in();
    chk("t6_no_stall", stalls[1], 0);
    drain(1);
    chk("t6_consecutive", maxrun1, 4);
    chk("t6_busy_after", bus1.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
